ddr_arbiter: RTL

Two-port arbiter and transaction sequencer between the CPU's instruction-fetch unit, the memory (LD/ST) stage, and the single DDR3 user-interface port. It grants one requester at a time, issues that requester's read or write command, runs the write-data or read-data phase, and returns completion, read data, or a timeout error to the granted requester. It sits between the pipeline front end / Memory stage and the DDR3 IP.

---
 rtl/ddr_arbiter.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/ddr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ddr_arbiter
// Brief    : Fetch / memory-stage arbiter and single-beat DDR3 UI sequencer.
//            Define DDR_ARB_RR_EN for round-robin arbitration (default: mem
//            has fixed priority over fetch).
// Revision : 1.0
// ============================================================================
module ddr_arbiter #(
    parameter int ADDR_W      = 29,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_rvalid_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic              mem_gnt_o,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_rvalid_o,
    output logic              mem_wdone_o,
    output logic              err_o,
    output logic              busy_o,
    input  logic              ddr_cmd_rdy_i,
    output logic              ddr_enable_o,
    output logic              ddr_cmd_o,
    output logic [ADDR_W-1:0] ddr_addr_o,
    input  logic [DATA_W-1:0] ddr_read_data_i,
    input  logic              ddr_read_data_valid_i,
    input  logic              ddr_read_data_end_i,
    input  logic              ddr_write_rdy_i,
    output logic              ddr_write_enable_o,
    output logic [DATA_W-1:0] ddr_write_data_o,
    output logic              ddr_write_data_end_o
);

    localparam int                 c_CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam bit                 c_TO_EN   = (TIMEOUT_CYC > 0);
    localparam logic [c_CNT_W-1:0] c_TO_LAST = (TIMEOUT_CYC > 0) ? c_CNT_W'(TIMEOUT_CYC - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CMD   = 2'd1,
        S_WDATA = 2'd2,
        S_RWAIT = 2'd3
    } state_t;

    state_t              r_state, w_state;
    logic                r_owner_mem, w_owner_mem;
    logic                r_we, w_we;
    logic [DATA_W-1:0]   r_wdata, w_wdata;
    logic [c_CNT_W-1:0]  r_cnt, w_cnt;
    logic [c_CNT_W-1:0]  w_cnt_inc;
    logic                r_have_beat, w_have_beat;
    logic [DATA_W-1:0]   r_beat, w_beat;

    logic                r_if_gnt, w_if_gnt;
    logic                r_mem_gnt, w_mem_gnt;
    logic                r_if_rvalid, w_if_rvalid;
    logic                r_mem_rvalid, w_mem_rvalid;
    logic                r_mem_wdone, w_mem_wdone;
    logic                r_err, w_err;
    logic                r_busy, w_busy;
    logic [DATA_W-1:0]   r_if_rdata, w_if_rdata;
    logic [DATA_W-1:0]   r_mem_rdata, w_mem_rdata;
    logic                r_ddr_en, w_ddr_en;
    logic                r_ddr_cmd, w_ddr_cmd;
    logic [ADDR_W-1:0]   r_ddr_addr, w_ddr_addr;
    logic                r_ddr_wen, w_ddr_wen;
    logic [DATA_W-1:0]   r_ddr_wdata, w_ddr_wdata;

    logic                w_pick_mem;
    logic                w_timeout;
    logic                w_done;
    logic                w_abort;
    logic                w_grant;

    assign w_grant   = (r_state == S_IDLE) && (mem_req_i || if_req_i);
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_timeout = c_TO_EN && (w_cnt_inc >= c_TO_LAST);

`ifdef DDR_ARB_RR_EN
    // Set when fetch owned the most recent grant; a tie goes to the other port.
    logic r_last_fetch;

    assign w_pick_mem = mem_req_i && (!if_req_i || r_last_fetch);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_fetch <= 1'b1;
        end else if (w_grant) begin
            r_last_fetch <= !w_pick_mem;
        end
    end
`else
    assign w_pick_mem = mem_req_i;
`endif

    always_comb begin
        w_state      = r_state;
        w_owner_mem  = r_owner_mem;
        w_we         = r_we;
        w_wdata      = r_wdata;
        w_cnt        = r_cnt;
        w_have_beat  = r_have_beat;
        w_beat       = r_beat;
        w_if_gnt     = 1'b0;
        w_mem_gnt    = 1'b0;
        w_if_rvalid  = 1'b0;
        w_mem_rvalid = 1'b0;
        w_mem_wdone  = 1'b0;
        w_err        = 1'b0;
        w_if_rdata   = r_if_rdata;
        w_mem_rdata  = r_mem_rdata;
        w_ddr_en     = r_ddr_en;
        w_ddr_cmd    = r_ddr_cmd;
        w_ddr_addr   = r_ddr_addr;
        w_ddr_wen    = r_ddr_wen;
        w_ddr_wdata  = r_ddr_wdata;
        w_done       = 1'b0;
        w_abort      = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_state     = S_CMD;
                    w_owner_mem = w_pick_mem;
                    w_we        = w_pick_mem & mem_we_i;
                    w_wdata     = mem_wdata_i;
                    w_ddr_en    = 1'b1;
                    w_ddr_cmd   = w_pick_mem & mem_we_i;
                    w_ddr_addr  = w_pick_mem ? mem_addr_i : if_addr_i;
                    w_if_gnt    = !w_pick_mem;
                    w_mem_gnt   = w_pick_mem;
                    w_cnt       = '0;
                    w_have_beat = 1'b0;
                end
            end
            S_CMD: begin
                w_cnt = w_cnt_inc;
                if (ddr_cmd_rdy_i) begin
                    w_ddr_en = 1'b0;
                    if (r_we) begin
                        w_state     = S_WDATA;
                        w_ddr_wen   = 1'b1;
                        w_ddr_wdata = r_wdata;
                    end else begin
                        w_state = S_RWAIT;
                    end
                end
            end
            S_WDATA: begin
                w_cnt = w_cnt_inc;
                if (ddr_write_rdy_i) begin
                    w_done      = 1'b1;
                    w_ddr_wen   = 1'b0;
                    w_mem_wdone = 1'b1;
                    w_state     = S_IDLE;
                end
            end
            S_RWAIT: begin
                w_cnt = w_cnt_inc;
                if (ddr_read_data_valid_i && ddr_read_data_end_i) begin
                    w_done  = 1'b1;
                    w_state = S_IDLE;
                    if (r_owner_mem) begin
                        w_mem_rvalid = 1'b1;
                        w_mem_rdata  = r_have_beat ? r_beat : ddr_read_data_i;
                    end else begin
                        w_if_rvalid = 1'b1;
                        w_if_rdata  = r_have_beat ? r_beat : ddr_read_data_i;
                    end
                end else if (ddr_read_data_valid_i && !r_have_beat) begin
                    w_have_beat = 1'b1;
                    w_beat      = ddr_read_data_i;
                end
            end
            default: w_state = S_IDLE;
        endcase

        // A completion on the timeout edge takes precedence over the error.
        w_abort = (r_state != S_IDLE) && w_timeout && !w_done;
        if (w_abort) begin
            w_state   = S_IDLE;
            w_ddr_en  = 1'b0;
            w_ddr_wen = 1'b0;
            w_err     = 1'b1;
            if (r_we) begin
                w_mem_wdone = 1'b1;
            end else if (r_owner_mem) begin
                w_mem_rvalid = 1'b1;
                w_mem_rdata  = '0;
            end else begin
                w_if_rvalid = 1'b1;
                w_if_rdata  = '0;
            end
        end

        w_busy = (w_state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_owner_mem  <= 1'b0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_have_beat  <= 1'b0;
            r_beat       <= '0;
            r_if_gnt     <= 1'b0;
            r_mem_gnt    <= 1'b0;
            r_if_rvalid  <= 1'b0;
            r_mem_rvalid <= 1'b0;
            r_mem_wdone  <= 1'b0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
            r_if_rdata   <= '0;
            r_mem_rdata  <= '0;
            r_ddr_en     <= 1'b0;
            r_ddr_cmd    <= 1'b0;
            r_ddr_addr   <= '0;
            r_ddr_wen    <= 1'b0;
            r_ddr_wdata  <= '0;
        end else begin
            r_state      <= w_state;
            r_owner_mem  <= w_owner_mem;
            r_we         <= w_we;
            r_wdata      <= w_wdata;
            r_cnt        <= w_cnt;
            r_have_beat  <= w_have_beat;
            r_beat       <= w_beat;
            r_if_gnt     <= w_if_gnt;
            r_mem_gnt    <= w_mem_gnt;
            r_if_rvalid  <= w_if_rvalid;
            r_mem_rvalid <= w_mem_rvalid;
            r_mem_wdone  <= w_mem_wdone;
            r_err        <= w_err;
            r_busy       <= w_busy;
            r_if_rdata   <= w_if_rdata;
            r_mem_rdata  <= w_mem_rdata;
            r_ddr_en     <= w_ddr_en;
            r_ddr_cmd    <= w_ddr_cmd;
            r_ddr_addr   <= w_ddr_addr;
            r_ddr_wen    <= w_ddr_wen;
            r_ddr_wdata  <= w_ddr_wdata;
        end
    end

    assign if_gnt_o             = r_if_gnt;
    assign if_rdata_o           = r_if_rdata;
    assign if_rvalid_o          = r_if_rvalid;
    assign mem_gnt_o            = r_mem_gnt;
    assign mem_rdata_o          = r_mem_rdata;
    assign mem_rvalid_o         = r_mem_rvalid;
    assign mem_wdone_o          = r_mem_wdone;
    assign err_o                = r_err;
    assign busy_o               = r_busy;
    assign ddr_enable_o         = r_ddr_en;
    assign ddr_cmd_o            = r_ddr_cmd;
    assign ddr_addr_o           = r_ddr_addr;
    assign ddr_write_enable_o   = r_ddr_wen;
    assign ddr_write_data_o     = r_ddr_wdata;
    assign ddr_write_data_end_o = r_ddr_wen;

endmodule
`default_nettype wire
